// File: rtl/framing_pkg.sv
// framing_pkg: shared definitions for the byte-wide framing blocks.
//   state_t        framer FSM states
//   CRC16_X25_*    X-25 CRC-16 constants (reflected)
//   CRC32_*        IEEE CRC-32 constants (reflected)
//   DEF_*          default preamble / SFD / gap settings
//   IDX_W          width of the shared per-state byte index
package framing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_PAYLOAD,
    ST_FCS,
    ST_GAP
  } state_t;

  localparam logic [15:0] CRC16_X25_POLY   = 16'h8408;
  localparam logic [15:0] CRC16_X25_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_X25_XOROUT = 16'hFFFF;

  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

  localparam int          DEF_PREAMBLE_LEN  = 8;
  localparam logic [7:0]  DEF_PREAMBLE_BYTE = 8'hAA;
  localparam int          DEF_SFD_BYTES     = 2;
  localparam logic [15:0] DEF_SFD           = 16'h98F3;
  localparam int          DEF_IFG_CYCLES    = 4;

  localparam int IDX_W = 16;

endpackage

// File: rtl/framer_crc_stream_crc_byte_step.sv
// crc_byte_step: one byte of a reflected (LSB-first) CRC, purely combinational.
// Shared by the framer and the deframer checker.
//   crc_in   [CRC_W-1:0]  current CRC
//   data_in  [7:0]        byte to absorb, bit 0 first
//   crc_out  [CRC_W-1:0]  CRC after the 8 bit steps
module crc_byte_step #(
  parameter int               CRC_W    = 16,
  parameter logic [CRC_W-1:0] CRC_POLY = 16'h8408
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [7:0]       data_in,
  output logic [CRC_W-1:0] crc_out
);

  logic [CRC_W-1:0] crc_acc;

  always_comb begin
    crc_acc = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_acc[0] ^ data_in[i]) begin
        crc_acc = (crc_acc >> 1) ^ CRC_POLY;
      end else begin
        crc_acc = crc_acc >> 1;
      end
    end
    crc_out = crc_acc;
  end

endmodule

// File: rtl/framer_crc_stream.sv
// framer_crc_stream: wraps a byte payload stream with preamble + SFD and
// appends the reflected CRC (FCS), followed by an optional inter-frame gap.
//   clk, reset_n                 clock, async active-low reset
//   s_data/s_valid/s_last/s_ready  payload input stream
//   m_data/m_valid/m_last/m_ready  framed output stream (m_last on final FCS byte)
//   busy                         high whenever the FSM is not idle
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for s_valid; CRC held at its preset
// PREAMBLE | sending PREAMBLE_LEN copies of PREAMBLE_BYTE
// SFD      | sending SFD bytes, LSB byte first
// PAYLOAD  | combinational pass-through, CRC absorbs each accepted byte
// FCS      | sending (crc ^ XOROUT), LSB byte first, m_last on the final byte
// GAP      | IFG_CYCLES idle cycles before returning to IDLE
module framer_crc_stream
  import framing_pkg::*;
#(
  parameter int                       PREAMBLE_LEN  = DEF_PREAMBLE_LEN,
  parameter logic [7:0]               PREAMBLE_BYTE = DEF_PREAMBLE_BYTE,
  parameter int                       SFD_BYTES     = DEF_SFD_BYTES,
  parameter logic [SFD_BYTES*8-1:0]   SFD           = DEF_SFD,
  parameter int                       CRC_W         = 16,
  parameter logic [CRC_W-1:0]         CRC_POLY      = CRC16_X25_POLY,
  parameter logic [CRC_W-1:0]         CRC_INIT      = CRC16_X25_INIT,
  parameter logic [CRC_W-1:0]         CRC_XOROUT    = CRC16_X25_XOROUT,
  parameter int                       IFG_CYCLES    = DEF_IFG_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       busy
);

  localparam int FCS_BYTES = CRC_W / 8;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] crc_step;
  logic [CRC_W-1:0] fcs;

  crc_byte_step #(
    .CRC_W    (CRC_W),
    .CRC_POLY (CRC_POLY)
  ) u_crc_step (
    .crc_in  (crc_q),
    .data_in (s_data),
    .crc_out (crc_step)
  );

  assign fcs  = crc_q ^ CRC_XOROUT;
  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      crc_q   <= CRC_INIT;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      crc_q   <= crc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    crc_d   = crc_q;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_last  = 1'b0;
    s_ready = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        crc_d = CRC_INIT;
        idx_d = '0;
        // the first payload byte stays on s_data until PAYLOAD accepts it
        if (s_valid) begin
          state_d = ST_PREAMBLE;
        end
      end

      ST_PREAMBLE: begin
        m_valid = 1'b1;
        m_data  = PREAMBLE_BYTE;
        if (m_ready) begin
          if (idx_q == IDX_W'(PREAMBLE_LEN - 1)) begin
            state_d = ST_SFD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ST_SFD: begin
        m_valid = 1'b1;
        for (int b = 0; b < SFD_BYTES; b++) begin
          if (idx_q == IDX_W'(b)) begin
            m_data = SFD[8*b +: 8];
          end
        end
        if (m_ready) begin
          if (idx_q == IDX_W'(SFD_BYTES - 1)) begin
            state_d = ST_PAYLOAD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ST_PAYLOAD: begin
        m_valid = s_valid;
        m_data  = s_data;
        s_ready = m_ready;
        if (s_valid && m_ready) begin
          crc_d = crc_step;
          if (s_last) begin
            state_d = ST_FCS;
            idx_d   = '0;
          end
        end
      end

      ST_FCS: begin
        m_valid = 1'b1;
        for (int b = 0; b < FCS_BYTES; b++) begin
          if (idx_q == IDX_W'(b)) begin
            m_data = fcs[8*b +: 8];
          end
        end
        m_last = (idx_q == IDX_W'(FCS_BYTES - 1));
        if (m_ready) begin
          if (m_last) begin
            state_d = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ST_GAP: begin
        if (idx_q == IDX_W'(IFG_CYCLES - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        crc_d   = CRC_INIT;
      end
    endcase
  end

endmodule

// File: doc/framer_crc_stream.md
# framer_crc_stream

Parametrised byte-wide frame generator. It wraps a payload stream with a preamble and a start-of-frame delimiter (SFD), then appends a reflected CRC as the frame check sequence (FCS). Valid/ready handshakes on both sides replace the single-cycle indicator pulses. The block sits between the MAC payload source and the PHY encoder, one byte per cycle. Any CRC width that is a multiple of 8 is supported, and an inter-frame gap is enforced.

## Interface
Parameters:
- PREAMBLE_LEN, 8: preamble byte count (≥1).
- PREAMBLE_BYTE, 8'hAA: preamble byte value.
- SFD_BYTES, 2: SFD byte count (≥1).
- SFD, 16'h98F3: SFD value, SFD_BYTES*8 wide, sent LSB byte first (F3, then 98).
- CRC_W, 16: CRC width, a multiple of 8 (16 or 32).
- CRC_POLY, 16'h8408: reflected polynomial.
- CRC_INIT, 16'hFFFF: CRC preset at frame start.
- CRC_XOROUT, 16'hFFFF: XOR mask applied to the CRC on output.
- IFG_CYCLES, 4: idle cycles after the last FCS byte; 0 means none.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_data  in  8  payload byte.
- s_valid  in  1  payload byte valid.
- s_last  in  1  marks the final payload byte.
- s_ready  out  1  payload byte accepted.
- m_data  out  8  framed output byte.
- m_valid  out  1  output byte valid.
- m_last  out  1  marks the final FCS byte.
- m_ready  in  1  downstream accepts the byte.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Transfers:
  - Output transfer (m_xfer) occurs when m_valid & m_ready.
  - Input transfer (s_xfer) occurs when s_valid & s_ready.
- States: IDLE, PREAMBLE, SFD, PAYLOAD, FCS, GAP. A single index counter covers PREAMBLE, SFD, FCS and GAP and is cleared on every state change.
- IDLE:
  - m_valid=0, s_ready=0, crc=CRC_INIT.
  - s_valid=1 moves to PREAMBLE. The byte is not consumed.
- PREAMBLE:
  - m_valid=1, m_data=PREAMBLE_BYTE.
  - The index advances on m_xfer.
  - After PREAMBLE_LEN transfers, moves to SFD.
- SFD:
  - m_data=SFD[8*idx+:8].
  - After SFD_BYTES transfers, moves to PAYLOAD.
- PAYLOAD, combinational pass-through:
  - m_valid=s_valid, s_ready=m_ready, m_data=s_data.
  - On s_xfer, the CRC is updated over the 8 bits, LSB first: per bit, fb=d[i]^crc[0]; crc=(crc>>1)^(fb?CRC_POLY:0).
  - s_xfer with s_last moves to FCS.
- FCS:
  - m_valid=1, s_ready=0.
  - m_data=(crc^CRC_XOROUT)[8*idx+:8], LSB byte first.
  - The CRC is held.
  - m_last=1 on byte CRC_W/8-1.
  - That byte's m_xfer moves to GAP, or to IDLE if IFG_CYCLES=0.
- GAP:
  - m_valid=0, s_ready=0.
  - Counts IFG_CYCLES cycles, then moves to IDLE.
- Boundaries:
  - A single-byte payload with s_last is legal.
  - Zero-length payloads are not supported.
  - s_last while m_ready=0 means no transfer; state and CRC hold.
  - s_valid dropping mid-payload: m_valid follows it, and the CRC and state hold.
  - m_data, m_last and m_valid are stable while m_valid=1 and m_ready=0. This holds in PREAMBLE, SFD and FCS. In PAYLOAD it holds provided the source respects its own handshake.
  - Frames cannot overlap. A new frame's s_valid is ignored until IDLE.
- Reset mid-frame:
  - The next state is IDLE with crc=CRC_INIT.
  - The partial frame is abandoned and no m_last is issued.

## Timing
- Reset values:
  - m_valid=0, m_last=0, m_data=8'h00, s_ready=0, busy=0.
  - state=IDLE, idx=0, crc=CRC_INIT.
- Outside PAYLOAD: m_data and m_valid are decoded from the registered state and idx, with no input combinational path.
- Inside PAYLOAD: zero-latency combinational paths s_data→m_data, s_valid→m_valid and m_ready→s_ready.
- First preamble byte: m_valid rises the cycle after s_valid is seen in IDLE.
- Minimum frame duration with m_ready held at 1: 1 + PREAMBLE_LEN + SFD_BYTES + N + CRC_W/8 + IFG_CYCLES cycles, where N is the payload byte count.
- The CRC register updates on the clock edge of each payload s_xfer. The FCS reads the post-update value in the cycle after the last s_xfer.

## Structure
- Shared package framing_pkg holds:
  - the state enum;
  - default constants: X-25 CRC-16 (8408/FFFF/FFFF), CRC-32 (EDB88320/FFFFFFFF/FFFFFFFF), and preamble/SFD defaults.
- Sub-module crc_byte_step (params CRC_W, CRC_POLY):
  - purely combinational;
  - crc_in plus byte in, crc_out out;
  - 8 unrolled reflected bit steps;
  - reused by the deframer checker.

## Test plan
- Defaults, m_ready=1, payload "123456789" (31…39):
  - Output is 8×AA, F3, 98, 31…39, 6E, 90.
  - m_last is on the byte 90.
  - 4 gap cycles follow, then IDLE.
- CRC_W=32 with CRC-32 constants, same payload:
  - FCS is 26, 39, F4, CB.
- Random m_ready and s_valid gaps (50%):
  - Byte sequence identical to the first scenario.
  - m_data stable while m_valid & !m_ready.
  - No byte lost or duplicated.
- Single-byte payload 00 with s_last:
  - The FCS equals the X-25 CRC of 00.
  - Two FCS bytes, m_last on the second.
- Back-to-back frames, s_valid held high, IFG_CYCLES=0:
  - The second preamble starts the cycle after the first m_last transfer plus 1 IDLE cycle.
  - The CRC is re-initialised, so both FCS values are correct.
- reset_n asserted during payload byte 3, then a new frame:
  - All outputs at reset values immediately; no m_last.
  - The next frame's FCS is correct, with no contamination from the aborted frame.
